c1541_gcr_track_loader: RTL and testbench

C1541_GCR_TRACK_LOADER -- requirements
Module: c1541_gcr_track_loader

---
 rtl/c1541_gcr_track_loader.sv | 190 +++++++++++++++++++
 tb/tb_c1541_gcr_track_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_gcr_track_loader.sv
// Moves one 8 KiB half-track slot between the SD image and the GCR track buffer.
// It flushes the dirty buffer before loading a new half-track once the head has settled.
module c1541_gcr_track_loader #(
  parameter logic [15:0] SETTLE_CLKS = 16'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        img_readonly,
  input  logic [6:0]  htrack,
  input  logic        mtr,
  input  logic        we,
  output logic [31:0] sd_lba,
  output logic [5:0]  sd_blk_cnt,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic        busy,
  output logic [6:0]  cur_htrack
);

  typedef enum logic [2:0] {
    S_NODISK, S_IDLE, S_SETTLE, S_FLUSH, S_FLUSH_WAIT, S_LOAD, S_LOAD_WAIT
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] lba_reg, lba_next;
  logic [6:0]  cur_reg, cur_next;
  logic [6:0]  tgt_reg, tgt_next;
  logic [6:0]  hprev_reg, hprev_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        dirty_reg, dirty_next;
  logic        pend_reg, pend_next;
  logic        pend_nodisk_reg, pend_nodisk_next;
  logic        flush_only_reg, flush_only_next;
  logic        mtr_d_reg, mtr_d_next;

  logic [6:0]  htrack_c;
  logic        mtr_fall;
  logic        dirty_now;
  logic        pend_now;
  logic        mount_nodisk;
  logic        do_mount;

  function automatic logic [31:0] slot_lba(input logic [6:0] h);
    slot_lba = {21'd0, h, 4'd0};
  endfunction

  assign htrack_c   = (htrack > 7'd83) ? 7'd83 : htrack;
  assign mtr_fall   = mtr_d_reg & ~mtr;
  assign sd_rd      = (state_reg == S_LOAD);
  assign sd_wr      = (state_reg == S_FLUSH);
  assign busy       = (state_reg != S_IDLE) && (state_reg != S_SETTLE);
  assign sd_lba     = lba_reg;
  assign sd_blk_cnt = 6'd15;
  assign cur_htrack = cur_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_NODISK;
      lba_reg         <= 32'd0;
      cur_reg         <= 7'd0;
      tgt_reg         <= 7'd0;
      hprev_reg       <= 7'd0;
      cnt_reg         <= 16'd0;
      dirty_reg       <= 1'b0;
      pend_reg        <= 1'b0;
      pend_nodisk_reg <= 1'b0;
      flush_only_reg  <= 1'b0;
      mtr_d_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lba_reg         <= lba_next;
      cur_reg         <= cur_next;
      tgt_reg         <= tgt_next;
      hprev_reg       <= hprev_next;
      cnt_reg         <= cnt_next;
      dirty_reg       <= dirty_next;
      pend_reg        <= pend_next;
      pend_nodisk_reg <= pend_nodisk_next;
      flush_only_reg  <= flush_only_next;
      mtr_d_reg       <= mtr_d_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    lba_next         = lba_reg;
    cur_next         = cur_reg;
    tgt_next         = tgt_reg;
    cnt_next         = cnt_reg;
    dirty_next       = dirty_reg;
    pend_next        = pend_reg;
    pend_nodisk_next = pend_nodisk_reg;
    flush_only_next  = flush_only_reg;
    mtr_d_next       = mtr;
    hprev_next       = htrack_c;
    do_mount         = 1'b0;
    dirty_now        = dirty_reg | (we & ~img_readonly);
    pend_now         = pend_reg | img_mounted;
    mount_nodisk     = img_mounted ? (img_size == 32'd0) : pend_nodisk_reg;

    // A mount arriving mid-transfer waits until the SD transaction has finished.
    if (img_mounted && (state_reg inside {S_FLUSH, S_FLUSH_WAIT, S_LOAD, S_LOAD_WAIT})) begin
      pend_next        = 1'b1;
      pend_nodisk_next = (img_size == 32'd0);
    end

    case (state_reg)
      S_NODISK: do_mount = img_mounted;

      S_IDLE, S_SETTLE: begin
        dirty_next = dirty_now;
        if (img_mounted) begin
          do_mount = 1'b1;
        end else if (mtr_fall && dirty_now) begin
          state_next      = S_FLUSH;
          lba_next        = slot_lba(cur_reg);
          flush_only_next = 1'b1;
        end else if (state_reg == S_IDLE) begin
          if (htrack_c != cur_reg) begin
            state_next = S_SETTLE;
            cnt_next   = SETTLE_CLKS;
          end
        end else if (htrack_c != hprev_reg) begin
          cnt_next = SETTLE_CLKS;
        end else if (cnt_reg != 16'd0) begin
          cnt_next = cnt_reg - 16'd1;
        end else if (htrack_c == cur_reg) begin
          state_next = S_IDLE;
        end else if (dirty_now) begin
          state_next      = S_FLUSH;
          lba_next        = slot_lba(cur_reg);
          flush_only_next = 1'b0;
        end else begin
          state_next = S_LOAD;
          tgt_next   = htrack_c;
          lba_next   = slot_lba(htrack_c);
        end
      end

      S_FLUSH: if (sd_ack) state_next = S_FLUSH_WAIT;

      S_LOAD: if (sd_ack) state_next = S_LOAD_WAIT;

      S_FLUSH_WAIT: begin
        if (!sd_ack) begin
          dirty_next      = 1'b0;
          flush_only_next = 1'b0;
          if (pend_now) begin
            do_mount = 1'b1;
          end else if (flush_only_reg || (htrack_c == cur_reg)) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_LOAD;
            tgt_next   = htrack_c;
            lba_next   = slot_lba(htrack_c);
          end
        end
      end

      S_LOAD_WAIT: begin
        if (!sd_ack) begin
          cur_next = tgt_reg;
          if (pend_now) do_mount = 1'b1;
          else          state_next = S_IDLE;
        end
      end

      default: state_next = S_NODISK;
    endcase

    // A new image invalidates any unflushed data from the old one.
    if (do_mount) begin
      dirty_next       = 1'b0;
      pend_next        = 1'b0;
      pend_nodisk_next = 1'b0;
      flush_only_next  = 1'b0;
      if (mount_nodisk) begin
        state_next = S_NODISK;
      end else begin
        state_next = S_LOAD;
        tgt_next   = htrack_c;
        lba_next   = slot_lba(htrack_c);
      end
    end
  end

endmodule

// File: tb/tb_c1541_gcr_track_loader.sv
// Randomized bench: an SD responder records every request and a track-level model
// predicts the request list, current half-track and busy state after each operation.
module tb_c1541_gcr_track_loader;

  localparam logic [15:0] SETTLE_P = 16'd40;
  localparam int          SETTLE   = 40;
  localparam logic [31:0] IMG_SIZE = 32'd174848;

  logic        clk = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic [31:0] img_size;
  logic        img_readonly;
  logic [6:0]  htrack;
  logic        mtr;
  logic        we;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        busy;
  logic [6:0]  cur_htrack;

  logic        resp_ack = 1'b0;
  logic        man_ack  = 1'b0;
  logic        resp_en  = 1'b0;
  assign sd_ack = resp_ack | man_ack;

  int n_tests = 0;
  int n_fail  = 0;

  // Requests: bit 32 = write, bits 31:0 = lba
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int          m_cur;
  bit          m_dirty;

  always #5 clk = ~clk;

  c1541_gcr_track_loader #(.SETTLE_CLKS(SETTLE_P)) dut (
    .clk(clk), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .img_readonly(img_readonly), .htrack(htrack), .mtr(mtr), .we(we),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .busy(busy), .cur_htrack(cur_htrack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // SD host model: random acknowledge latency and length.
  initial begin
    logic [31:0] lba;
    forever begin
      @(negedge clk);
      if (resp_en && (sd_rd || sd_wr)) begin
        check("rd_wr_exclusive", {63'd0, sd_rd & sd_wr}, 64'd0);
        check("blk_cnt", {58'd0, sd_blk_cnt}, 64'd15);
        got_q.push_back({sd_wr, sd_lba});
        lba = sd_lba;
        $display("[TB] request %s lba=%0d", sd_wr ? "WR" : "RD", sd_lba);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        resp_ack = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        check("lba_stable", {32'd0, sd_lba}, {32'd0, lba});
        resp_ack = 1'b0;
      end
    end
  end

  function automatic logic [31:0] slot(input int h);
    slot = 32'(h) * 32'd16;
  endfunction

  function automatic int clamp(input int h);
    clamp = (h > 83) ? 83 : h;
  endfunction

  task automatic model_seek(input int h);
    int hc;
    hc = clamp(h);
    if (hc != m_cur) begin
      if (m_dirty) exp_q.push_back({1'b1, slot(m_cur)});
      exp_q.push_back({1'b0, slot(hc)});
      m_cur   = hc;
      m_dirty = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit settle_first);
    int n;
    if (settle_first) repeat (SETTLE + 6) @(negedge clk);
    n = 0;
    while ((busy || sd_ack) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("idle_timeout", 64'd1, 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_req(input bit wr, output bit ok);
    int n;
    n = 0;
    while (!(wr ? sd_wr : sd_rd) && n < SETTLE + 100) begin
      @(negedge clk);
      n++;
    end
    ok = (wr ? sd_wr : sd_rd);
    if (!ok) check("req_timeout", 64'd1, 64'd0);
  endtask

  task automatic compare_reqs(input string tag);
    int n;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_req"}, {31'd0, got_q[i]}, {31'd0, exp_q[i]});
    check({tag, "_cur"}, {57'd0, cur_htrack}, 64'(m_cur));
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    $display("[TB] %s: %0d requests, cur_htrack=%0d", tag, got_q.size(), cur_htrack);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_we(input int n);
    for (int i = 0; i < n; i++) begin
      we = 1'b1;
      @(negedge clk);
      we = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic mount(input logic [31:0] size, input int h);
    img_size    = size;
    htrack      = 7'(h);
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
  endtask

  initial begin
    bit ok;
    int h, seen, busy_seen, op, nwe;
    bit ro;

    reset = 1'b1; img_mounted = 1'b0; img_size = 32'd0; img_readonly = 1'b0;
    htrack = 7'd0; mtr = 1'b1; we = 1'b0;
    m_cur = 0; m_dirty = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_rd", {63'd0, sd_rd}, 64'd0);
    check("rst_wr", {63'd0, sd_wr}, 64'd0);
    check("rst_lba", {32'd0, sd_lba}, 64'd0);
    check("rst_blk", {58'd0, sd_blk_cnt}, 64'd15);
    check("rst_cur", {57'd0, cur_htrack}, 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("nodisk_busy", {63'd0, busy}, 64'd1);
    resp_en = 1'b1;

    // First mount loads the requested half-track
    mount(IMG_SIZE, 36);
    exp_q.push_back({1'b0, slot(36)});
    m_cur = 36;
    wait_idle(1'b0);
    compare_reqs("mount36");

    // Head wobble that returns to the same half-track within the settle window
    htrack = 7'd37;
    busy_seen = 0;
    repeat (10) begin @(negedge clk); busy_seen += int'(busy | sd_rd | sd_wr); end
    htrack = 7'd36;
    repeat (SETTLE + 20) begin @(negedge clk); busy_seen += int'(busy | sd_rd | sd_wr); end
    check("wobble_busy", 64'(busy_seen), 64'd0);
    compare_reqs("wobble");

    // Dirty buffer is flushed before the new half-track loads
    pulse_we(1);
    m_dirty = 1'b1;
    htrack = 7'd38;
    model_seek(38);
    wait_idle(1'b1);
    compare_reqs("flush_load38");
    htrack = 7'd40;
    model_seek(40);
    wait_idle(1'b1);
    compare_reqs("clean_load40");

    // Randomized seeks, writes and motor stops
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        mtr = 1'b0;
        repeat (2) @(negedge clk);
        mtr = 1'b1;
        if (m_dirty) exp_q.push_back({1'b1, slot(m_cur)});
        m_dirty = 1'b0;
        wait_idle(1'b0);
      end else begin
        nwe = $urandom_range(0, 2);
        ro  = 1'($urandom_range(0, 1));
        img_readonly = ro;
        pulse_we(nwe);
        img_readonly = 1'b0;
        if (nwe > 0 && !ro) m_dirty = 1'b1;
        h = $urandom_range(0, 100);
        htrack = 7'(h);
        model_seek(h);
        wait_idle(1'b1);
      end
      compare_reqs("rand");
    end

    // Clean up, then read-only writes and a motor stop must not write back
    mtr = 1'b0;
    repeat (2) @(negedge clk);
    mtr = 1'b1;
    if (m_dirty) exp_q.push_back({1'b1, slot(m_cur)});
    m_dirty = 1'b0;
    wait_idle(1'b0);
    compare_reqs("flush_clean");
    img_readonly = 1'b1;
    pulse_we(3);
    mtr = 1'b0;
    repeat (20) @(negedge clk);
    mtr = 1'b1;
    img_readonly = 1'b0;
    wait_idle(1'b0);
    compare_reqs("readonly");

    // Mount of an empty image during the load handshake
    resp_en = 1'b0;
    h = (m_cur + 5) % 80;
    htrack = 7'(h);
    wait_req(1'b0, ok);
    check("ej_lba", {32'd0, sd_lba}, {32'd0, slot(h)});
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    mount(32'd0, h);
    man_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("ej_busy", {63'd0, busy}, 64'd1);
    check("ej_cur", {57'd0, cur_htrack}, 64'(h));
    htrack = 7'(clamp(h + 7));
    pulse_we(2);
    seen = 0;
    repeat (2 * SETTLE) begin @(negedge clk); seen += int'(sd_rd | sd_wr); end
    check("ej_no_req", 64'(seen), 64'd0);
    check("ej_busy_hold", {63'd0, busy}, 64'd1);

    // Out-of-range half-track is clamped to 83
    mount(IMG_SIZE, 100);
    wait_req(1'b0, ok);
    check("clamp_lba", {32'd0, sd_lba}, 64'd1328);
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    man_ack = 1'b0;
    wait_idle(1'b0);
    check("clamp_cur", {57'd0, cur_htrack}, 64'd83);

    // Reset during a write-back drops sd_wr without a clock edge
    pulse_we(1);
    htrack = 7'd10;
    wait_req(1'b1, ok);
    check("wb_lba", {32'd0, sd_lba}, 64'd1328);
    #1 reset = 1'b1;
    #1;
    check("async_wr", {63'd0, sd_wr}, 64'd0);
    check("async_busy", {63'd0, busy}, 64'd1);
    check("async_lba", {32'd0, sd_lba}, 64'd0);
    check("async_cur", {57'd0, cur_htrack}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); seen += int'(sd_rd | sd_wr); end
    check("post_rst_idle", 64'(seen), 64'd0);

    // After reset the dirty data is gone: remount only reads
    m_cur = 0; m_dirty = 1'b0;
    resp_en = 1'b1;
    mount(IMG_SIZE, 10);
    exp_q.push_back({1'b0, slot(10)});
    m_cur = 10;
    wait_idle(1'b0);
    compare_reqs("remount");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
